// File: rtl/axi_lite_regfile_pkg.sv
// Shared definitions for the AXI4-Lite register file: response codes,
// channel FSM state encodings and a constant log2 helper.
package axi_lite_regfile_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE   = 2'd0,
        W_HAVE_A = 2'd1,
        W_HAVE_D = 2'd2,
        W_RESP   = 2'd3
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_RESP = 1'b1
    } rd_state_t;

    // Ceiling log2, used for elaboration-time widths only.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/axi_lite_regfile_wch.sv
// Write-channel engine: accepts AW and W in either order (or together),
// holds whichever arrives first, raises a one-cycle commit strobe when the
// pair is complete, and then holds B until the master takes it.
// Handshake rule on every channel: a transfer happens on the rising edge
// where both VALID and READY are high; READY never depends on VALID.
module axi_lite_regfile_wch
    import axi_lite_regfile_pkg::*;
#(
    parameter int DW    = 32,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] aw_idx,
    input  logic             aw_valid,
    output logic             aw_ready,
    input  logic [DW-1:0]    w_data,
    input  logic [DW/8-1:0]  w_strb,
    input  logic             w_valid,
    output logic             w_ready,
    output logic             b_valid,
    output logic [1:0]       b_resp,
    input  logic             b_ready,
    output logic             commit,
    output logic [IDX_W-1:0] commit_idx,
    output logic [DW-1:0]    commit_data,
    output logic [DW/8-1:0]  commit_strb,
    input  logic [1:0]       commit_resp,
    output wr_state_t        state
);

    wr_state_t        state_q, state_d;
    logic             live_q, live_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [DW-1:0]    data_q, data_d;
    logic [DW/8-1:0]  strb_q, strb_d;
    logic [1:0]       bresp_q, bresp_d;
    logic             aw_hs, w_hs;

    // READYs stay low until the first edge after reset release.
    assign live_d   = 1'b1;
    assign aw_ready = live_q && (state_q == W_IDLE || state_q == W_HAVE_D);
    assign w_ready  = live_q && (state_q == W_IDLE || state_q == W_HAVE_A);
    assign aw_hs    = aw_valid && aw_ready;
    assign w_hs     = w_valid && w_ready;
    assign b_valid  = (state_q == W_RESP);
    assign b_resp   = bresp_q;
    assign state    = state_q;

    // Commit payload: the half captured earlier comes from the holding regs.
    assign commit_idx  = (state_q == W_HAVE_A) ? idx_q  : aw_idx;
    assign commit_data = (state_q == W_HAVE_D) ? data_q : w_data;
    assign commit_strb = (state_q == W_HAVE_D) ? strb_q : w_strb;

    // Next-state, holding-register capture and commit detection.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        strb_d  = strb_q;
        bresp_d = bresp_q;
        commit  = 1'b0;
        case (state_q)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    commit = 1'b1;
                end else if (aw_hs) begin
                    idx_d   = aw_idx;
                    state_d = W_HAVE_A;
                end else if (w_hs) begin
                    data_d  = w_data;
                    strb_d  = w_strb;
                    state_d = W_HAVE_D;
                end
            end
            W_HAVE_A: if (w_hs)  commit = 1'b1;
            W_HAVE_D: if (aw_hs) commit = 1'b1;
            W_RESP:   if (b_ready) state_d = W_IDLE;
            default:  state_d = W_IDLE;
        endcase
        if (commit) begin
            state_d = W_RESP;
            bresp_d = commit_resp;
        end
    end

    // State and holding registers; reset abandons any partial transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= W_IDLE;
            live_q  <= 1'b0;
            idx_q   <= '0;
            data_q  <= '0;
            strb_q  <= '0;
            bresp_q <= RESP_OKAY;
        end else begin
            state_q <= state_d;
            live_q  <= live_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            strb_q  <= strb_d;
            bresp_q <= bresp_d;
        end
    end

endmodule

// File: rtl/axi_lite_regfile.sv
// Parametrised AXI4-Lite register file with byte strobes, read-only status
// mapping, SLVERR/DECERR responses and per-register write pulses.
// Optional build macro AXI_LITE_REGFILE_IRQ_EN turns the last register into
// a sticky W1C pending register and drives irq from pending & enable, where
// the enable mask is the second-to-last register.
module axi_lite_regfile
    import axi_lite_regfile_pkg::*;
#(
    parameter int                  C_S_AXI_DATA_WIDTH = 32,
    parameter int                  C_S_AXI_ADDR_WIDTH = 6,
    parameter int                  NUM_REGS           = 16,
    parameter logic [NUM_REGS-1:0] RO_MASK            = '0
) (
    input  logic                               S_AXI_ACLK,
    input  logic                               S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]      S_AXI_AWADDR,
    input  logic [2:0]                         S_AXI_AWPROT,
    input  logic                               S_AXI_AWVALID,
    output logic                               S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]      S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]    S_AXI_WSTRB,
    input  logic                               S_AXI_WVALID,
    output logic                               S_AXI_WREADY,
    output logic [1:0]                         S_AXI_BRESP,
    output logic                               S_AXI_BVALID,
    input  logic                               S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]      S_AXI_ARADDR,
    input  logic [2:0]                         S_AXI_ARPROT,
    input  logic                               S_AXI_ARVALID,
    output logic                               S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]      S_AXI_RDATA,
    output logic [1:0]                         S_AXI_RRESP,
    output logic                               S_AXI_RVALID,
    input  logic                               S_AXI_RREADY,
    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
    input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] status_in,
    output logic [NUM_REGS-1:0]                wr_pulse,
    output logic                               irq
);

    localparam int DW       = C_S_AXI_DATA_WIDTH;
    localparam int AW       = C_S_AXI_ADDR_WIDTH;
    localparam int SW       = DW / 8;
    localparam int ADDR_LSB = clog2(SW);
    localparam int IDX_W    = AW - ADDR_LSB;
    localparam int P        = NUM_REGS - 1;

`ifdef AXI_LITE_REGFILE_IRQ_EN
    localparam logic [NUM_REGS-1:0] RO_EFF = RO_MASK & ~(NUM_REGS'(1) << P);
`else
    localparam logic [NUM_REGS-1:0] RO_EFF = RO_MASK;
`endif

    logic [DW-1:0]       regs_q [NUM_REGS];
    logic [DW-1:0]       regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;
    logic                irq_q, irq_d;
    rd_state_t           rd_state_q, rd_state_d;
    logic                rd_live_q, rd_live_d;
    logic [DW-1:0]       rdata_q, rdata_d;
    logic [1:0]          rresp_q, rresp_d;

    logic                commit;
    logic [IDX_W-1:0]    commit_idx;
    logic [DW-1:0]       commit_data;
    logic [SW-1:0]       commit_strb;
    logic [1:0]          commit_resp;
    wr_state_t           wr_state;
    logic [IDX_W-1:0]    aw_idx, ar_idx;
    logic                unused_inputs;

    assign aw_idx = S_AXI_AWADDR[AW-1:ADDR_LSB];
    assign ar_idx = S_AXI_ARADDR[AW-1:ADDR_LSB];
    assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR,
                             S_AXI_ARADDR, status_in, wr_state};

    axi_lite_regfile_wch #(.DW(DW), .IDX_W(IDX_W)) u_wch (
        .clk         (S_AXI_ACLK),
        .rst         (S_AXI_ARESET),
        .aw_idx      (aw_idx),
        .aw_valid    (S_AXI_AWVALID),
        .aw_ready    (S_AXI_AWREADY),
        .w_data      (S_AXI_WDATA),
        .w_strb      (S_AXI_WSTRB),
        .w_valid     (S_AXI_WVALID),
        .w_ready     (S_AXI_WREADY),
        .b_valid     (S_AXI_BVALID),
        .b_resp      (S_AXI_BRESP),
        .b_ready     (S_AXI_BREADY),
        .commit      (commit),
        .commit_idx  (commit_idx),
        .commit_data (commit_data),
        .commit_strb (commit_strb),
        .commit_resp (commit_resp),
        .state       (wr_state)
    );

    // Classify the committing index: missing -> DECERR, read-only -> SLVERR.
    always_comb begin
        commit_resp = RESP_DECERR;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (commit_idx == IDX_W'(i)) commit_resp = RO_EFF[i] ? RESP_SLVERR : RESP_OKAY;
        end
    end

    // Byte-strobed register update, write pulses and the optional pending/irq logic.
    always_comb begin
`ifdef AXI_LITE_REGFILE_IRQ_EN
        logic [DW-1:0] pend_clr;
`endif
        for (int i = 0; i < NUM_REGS; i++) regs_d[i] = regs_q[i];
        wr_pulse_d = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (commit && commit_resp == RESP_OKAY && commit_idx == IDX_W'(i)) begin
                wr_pulse_d[i] = 1'b1;
                for (int b = 0; b < SW; b++) begin
                    if (commit_strb[b]) regs_d[i][b*8 +: 8] = commit_data[b*8 +: 8];
                end
            end
        end
`ifdef AXI_LITE_REGFILE_IRQ_EN
        pend_clr = '0;
        if (commit && commit_idx == IDX_W'(P)) begin
            for (int b = 0; b < SW; b++) begin
                if (commit_strb[b]) pend_clr[b*8 +: 8] = commit_data[b*8 +: 8];
            end
        end
        // Sticky set is OR-ed in after the clear so a same-cycle set wins.
        regs_d[P] = (regs_q[P] & ~pend_clr) | status_in[P*DW +: DW];
        irq_d     = |(regs_d[P] & regs_d[P-1]);
`else
        irq_d = 1'b0;
`endif
    end

    // Read channel: one-cycle load of RDATA/RRESP, held until RREADY.
    assign rd_live_d     = 1'b1;
    assign S_AXI_ARREADY = rd_live_q && (rd_state_q == R_IDLE);
    assign S_AXI_RVALID  = (rd_state_q == R_RESP);
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;

    // Read FSM next state and data selection; sees pre-write register values.
    always_comb begin
        rd_state_d = rd_state_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        case (rd_state_q)
            R_IDLE: begin
                if (S_AXI_ARVALID && S_AXI_ARREADY) begin
                    rd_state_d = R_RESP;
                    rdata_d    = '0;
                    rresp_d    = RESP_DECERR;
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (ar_idx == IDX_W'(i)) begin
                            rresp_d = RESP_OKAY;
                            rdata_d = RO_EFF[i] ? status_in[i*DW +: DW] : regs_q[i];
                        end
                    end
                end
            end
            R_RESP:  if (S_AXI_RREADY) rd_state_d = R_IDLE;
            default: rd_state_d = R_IDLE;
        endcase
    end

    // All architectural state with asynchronous clear.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            wr_pulse_q <= '0;
            irq_q      <= 1'b0;
            rd_state_q <= R_IDLE;
            rd_live_q  <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
            wr_pulse_q <= wr_pulse_d;
            irq_q      <= irq_d;
            rd_state_q <= rd_state_d;
            rd_live_q  <= rd_live_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

    assign wr_pulse = wr_pulse_q;
    assign irq      = irq_q;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
        assign reg_out[g*DW +: DW] = regs_q[g];
    end

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Bench for axi_lite_regfile: 16 x 32-bit registers, 7-bit address so that
// 0x40 decodes to a missing index, register 5 read-only with status 0xCAFE.
module tb_axi_lite_regfile;

    localparam int DW = 32;
    localparam int AW = 7;
    localparam int NR = 16;

    logic              clk;
    logic              rst;
    logic [AW-1:0]     awaddr, araddr;
    logic              awvalid, awready, wvalid, wready;
    logic [DW-1:0]     wdata;
    logic [3:0]        wstrb;
    logic [1:0]        bresp, rresp;
    logic              bvalid, bready, arvalid, arready, rvalid, rready;
    logic [DW-1:0]     rdata;
    logic [NR*DW-1:0]  reg_out, status_in;
    logic [NR-1:0]     wr_pulse;
    logic              irq;

    axi_lite_regfile #(
        .C_S_AXI_DATA_WIDTH (DW),
        .C_S_AXI_ADDR_WIDTH (AW),
        .NUM_REGS           (NR),
        .RO_MASK            (16'h0020)
    ) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESET  (rst),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (3'b000),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (3'b000),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .reg_out       (reg_out),
        .status_in     (status_in),
        .wr_pulse      (wr_pulse),
        .irq           (irq)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int pulse_cnt [NR];
    int exp_pulse [NR];

    logic [1:0]    exp_b_q [$];
    logic [33:0]   exp_r_q [$];

    typedef struct {
        bit          is_wr;
        logic [6:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
    } vec_t;

    vec_t vecs [21];

    // Count every sampled cycle a pulse is high; a stretched pulse overcounts.
    always @(negedge clk) begin
        for (int i = 0; i < NR; i++) if (wr_pulse[i]) pulse_cnt[i]++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        $display("FAIL %s: timeout waiting for DUT", name);
    endtask

    task automatic do_write(input logic [6:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input logic [1:0] exp_resp, input int aw_lag, input int w_lag, input int b_stall);
        int cyc;
        bit aw_done, w_done, hs_aw, hs_w;
        logic [1:0] resp0;
        logic [1:0] e;
        cyc = 0; aw_done = 0; w_done = 0;
        exp_b_q.push_back(exp_resp);
        bready = (b_stall == 0);
        awaddr = addr; wdata = data; wstrb = strb;
        while (!(aw_done && w_done) && cyc < 40) begin
            awvalid = !aw_done && (cyc >= aw_lag);
            wvalid  = !w_done && (cyc >= w_lag);
            hs_aw = awvalid && awready;
            hs_w  = wvalid && wready;
            @(negedge clk);
            cyc++;
            if (hs_aw) aw_done = 1;
            if (hs_w)  w_done = 1;
        end
        awvalid = 0; wvalid = 0;
        if (!(aw_done && w_done)) begin
            timeout_fail("aw_w_handshake");
            void'(exp_b_q.pop_front());
            return;
        end
        check("b_latency", bvalid, 1'b1);
        cyc = 0;
        while (!bvalid && cyc < 20) begin @(negedge clk); cyc++; end
        if (!bvalid) begin
            timeout_fail("bvalid");
            void'(exp_b_q.pop_front());
            return;
        end
        resp0 = bresp;
        repeat (b_stall) begin
            check("b_hold", {bvalid, bresp}, {1'b1, resp0});
            check("aw_w_blocked", {awready, wready}, 2'b00);
            @(negedge clk);
        end
        bready = 1;
        e = exp_b_q.pop_front();
        check("bresp", bresp, e);
        @(negedge clk);
        bready = 0;
        check("b_done", bvalid, 1'b0);
    endtask

    task automatic do_read(input logic [6:0] addr, input logic [1:0] exp_resp, input logic [31:0] exp_data,
                           input int r_stall);
        int cyc;
        logic [33:0] d0;
        logic [33:0] e;
        exp_r_q.push_back({exp_resp, exp_data});
        rready = (r_stall == 0);
        araddr = addr; arvalid = 1;
        cyc = 0;
        while (!arready && cyc < 40) begin @(negedge clk); cyc++; end
        if (!arready) begin
            arvalid = 0;
            timeout_fail("ar_handshake");
            void'(exp_r_q.pop_front());
            return;
        end
        @(negedge clk);
        arvalid = 0;
        check("r_latency", rvalid, 1'b1);
        cyc = 0;
        while (!rvalid && cyc < 20) begin @(negedge clk); cyc++; end
        if (!rvalid) begin
            timeout_fail("rvalid");
            void'(exp_r_q.pop_front());
            return;
        end
        d0 = {rresp, rdata};
        repeat (r_stall) begin
            check("r_hold", {rvalid, rresp, rdata}, {1'b1, d0});
            check("ar_blocked", arready, 1'b0);
            @(negedge clk);
        end
        rready = 1;
        e = exp_r_q.pop_front();
        check("rdata_rresp", {rresp, rdata}, e);
        @(negedge clk);
        rready = 0;
        check("r_done", rvalid, 1'b0);
    endtask

    // Global time bound
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  eb;
        logic [33:0] er;
        for (int i = 0; i < NR; i++) begin pulse_cnt[i] = 0; exp_pulse[i] = 0; end
        rst = 1;
        awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
        araddr = '0; arvalid = 0; rready = 0;
        status_in = '0;
        status_in[5*DW +: DW] = 32'h0000CAFE;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_handshake_outs", {awready, wready, arready, bvalid, rvalid}, 5'b0);
        check("reset_resp_data", {bresp, rresp, rdata}, 36'h0);
        check("reset_reg_out_lo", reg_out[255:0], 256'h0);
        check("reset_reg_out_hi", reg_out[511:256], 256'h0);
        check("reset_pulse_irq", {wr_pulse, irq}, 17'h0);
        rst = 0;
        check("ready_low_at_release", {awready, wready, arready}, 3'b000);
        @(negedge clk);
        check("ready_after_first_edge", {awready, wready, arready}, 3'b111);

        // Vector table: data is write data for writes, expected RDATA for reads.
        vecs[0]  = '{1, 7'h00, 32'h00000001, 4'hF, 2'b00};
        vecs[1]  = '{1, 7'h04, 32'h00000002, 4'hF, 2'b00};
        vecs[2]  = '{1, 7'h08, 32'h00000003, 4'hF, 2'b00};
        vecs[3]  = '{1, 7'h0C, 32'h00000004, 4'hF, 2'b00};
        vecs[4]  = '{0, 7'h00, 32'h00000001, 4'h0, 2'b00};
        vecs[5]  = '{0, 7'h04, 32'h00000002, 4'h0, 2'b00};
        vecs[6]  = '{0, 7'h08, 32'h00000003, 4'h0, 2'b00};
        vecs[7]  = '{0, 7'h0C, 32'h00000004, 4'h0, 2'b00};
        vecs[8]  = '{1, 7'h00, 32'hFFFFFFFF, 4'hF, 2'b00};
        vecs[9]  = '{1, 7'h00, 32'h12345678, 4'h5, 2'b00};
        vecs[10] = '{0, 7'h00, 32'hFF34FF78, 4'h0, 2'b00};
        vecs[11] = '{1, 7'h14, 32'h00000005, 4'hF, 2'b10};
        vecs[12] = '{0, 7'h14, 32'h0000CAFE, 4'h0, 2'b00};
        vecs[13] = '{0, 7'h40, 32'h00000000, 4'h0, 2'b11};
        vecs[14] = '{1, 7'h40, 32'hDEADBEEF, 4'hF, 2'b11};
        vecs[15] = '{1, 7'h0C, 32'hAAAAAAAA, 4'h0, 2'b00};
        vecs[16] = '{0, 7'h0C, 32'h00000004, 4'h0, 2'b00};
        vecs[17] = '{1, 7'h06, 32'h11223344, 4'hF, 2'b00};
        vecs[18] = '{0, 7'h05, 32'h11223344, 4'h0, 2'b00};
        vecs[19] = '{1, 7'h08, 32'h00AB0000, 4'h4, 2'b00};
        vecs[20] = '{0, 7'h08, 32'h00AB0003, 4'h0, 2'b00};

        for (int v = 0; v < 21; v++) begin
            if (vecs[v].is_wr) begin
                do_write(vecs[v].addr, vecs[v].data, vecs[v].strb, vecs[v].resp, 0, 0, 0);
                if (vecs[v].resp == 2'b00) exp_pulse[int'(vecs[v].addr[6:2])]++;
            end else begin
                do_read(vecs[v].addr, vecs[v].resp, vecs[v].data, 0);
            end
        end
        check("reg_out0", reg_out[0*DW +: DW], 32'hFF34FF78);
        check("reg_out1", reg_out[1*DW +: DW], 32'h11223344);
        check("reg_out2", reg_out[2*DW +: DW], 32'h00AB0003);
        check("reg_out3", reg_out[3*DW +: DW], 32'h00000004);
        check("reg_out5_ro", reg_out[5*DW +: DW], 32'h0);

        // AW three cycles ahead of W, then W three cycles ahead of AW.
        do_write(7'h10, 32'h00000055, 4'hF, 2'b00, 0, 3, 0);
        exp_pulse[4]++;
        do_write(7'h18, 32'h00000066, 4'hF, 2'b00, 3, 0, 0);
        exp_pulse[6]++;
        do_read(7'h10, 2'b00, 32'h00000055, 0);
        do_read(7'h18, 2'b00, 32'h00000066, 0);

        // Back-pressure on B and R for five cycles.
        do_write(7'h1C, 32'h00000077, 4'hF, 2'b00, 0, 0, 5);
        exp_pulse[7]++;
        do_read(7'h1C, 2'b00, 32'h00000077, 5);

        // Read and write to the same register on the same edge.
        exp_b_q.push_back(2'b00);
        exp_r_q.push_back({2'b00, 32'h00AB0003});
        check("collide_ready", {awready, wready, arready}, 3'b111);
        awaddr = 7'h08; wdata = 32'h00000099; wstrb = 4'hF; araddr = 7'h08;
        awvalid = 1; wvalid = 1; arvalid = 1; bready = 1; rready = 1;
        @(negedge clk);
        awvalid = 0; wvalid = 0; arvalid = 0;
        check("collide_valids", {bvalid, rvalid}, 2'b11);
        eb = exp_b_q.pop_front();
        check("collide_bresp", bresp, eb);
        er = exp_r_q.pop_front();
        check("collide_rdata_old", {rresp, rdata}, er);
        @(negedge clk);
        bready = 0; rready = 0;
        exp_pulse[2]++;
        do_read(7'h08, 2'b00, 32'h00000099, 0);

`ifdef AXI_LITE_REGFILE_IRQ_EN
        // Enable bit 0, pulse status bit 0, then clear it with W1C.
        do_write(7'h38, 32'h00000001, 4'hF, 2'b00, 0, 0, 0);
        exp_pulse[14]++;
        check("irq_idle", irq, 1'b0);
        status_in[15*DW] = 1'b1;
        @(negedge clk);
        status_in[15*DW] = 1'b0;
        check("irq_set", irq, 1'b1);
        @(negedge clk);
        check("irq_sticky", irq, 1'b1);
        do_read(7'h3C, 2'b00, 32'h00000001, 0);
        do_write(7'h3C, 32'h00000001, 4'hF, 2'b00, 0, 0, 0);
        exp_pulse[15]++;
        check("irq_cleared", irq, 1'b0);
        do_read(7'h3C, 2'b00, 32'h00000000, 0);
`else
        check("irq_tied_low", irq, 1'b0);
`endif

        // Write pulse accounting, one check per register.
        for (int i = 0; i < NR; i++) check($sformatf("pulse_count_%0d", i), pulse_cnt[i], exp_pulse[i]);

        // Reset while an address is held waiting for data.
        awaddr = 7'h00; awvalid = 1;
        check("mid_aw_ready", awready, 1'b1);
        @(negedge clk);
        awvalid = 0;
        check("have_a_readies", {awready, wready}, 2'b01);
        rst = 1;
        @(negedge clk);
        check("mid_reset_outs", {bvalid, awready, wready, arready}, 4'b0);
        check("mid_reset_regs", reg_out[255:0], 256'h0);
        rst = 0;
        @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            check("no_orphan_b", bvalid, 1'b0);
            @(negedge clk);
        end
        do_read(7'h00, 2'b00, 32'h00000000, 0);
        do_read(7'h04, 2'b00, 32'h00000000, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/axi_lite_regfile.md
Name: axi_lite_regfile

Overview:
Parametrised AXI4-Lite slave register file, the successor to the fixed 4-register axi_lite slave. It provides NUM_REGS registers of configurable width, with byte strobes, per-register read-only status mapping, decode/access error responses and per-register write pulses. It sits behind the PS/interconnect master port and supplies control and status registers to the CNN datapath.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data width; legal values 32 or 64.
C_S_AXI_ADDR_WIDTH, 6, byte address width; must satisfy 2**(ADDR_W-ADDR_LSB) >= NUM_REGS.
NUM_REGS, 16, number of registers; 2..64.
RO_MASK, 0, NUM_REGS-bit mask; bit i=1 makes register i read-only, with reads returning status_in slice i.

Ports:
S_AXI_ACLK  in  1  clock
S_AXI_ARESET  in  1  asynchronous active-high reset
S_AXI_AWADDR  in  ADDR_W  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID/S_AXI_AWREADY  in/out  1  AW handshake
S_AXI_WDATA  in  DW  write data
S_AXI_WSTRB  in  DW/8  byte strobes
S_AXI_WVALID/S_AXI_WREADY  in/out  1  W handshake
S_AXI_BRESP  out  2  write response
S_AXI_BVALID/S_AXI_BREADY  out/in  1  B handshake
S_AXI_ARADDR  in  ADDR_W  read address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID/S_AXI_ARREADY  in/out  1  AR handshake
S_AXI_RDATA  out  DW  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID/S_AXI_RREADY  out/in  1  R handshake
reg_out  out  NUM_REGS*DW  flattened register contents; register i occupies [i*DW +: DW]
status_in  in  NUM_REGS*DW  status values for RO registers; slices of RW registers are unused
wr_pulse  out  NUM_REGS  1-cycle strobe on each committed write to register i
irq  out  1  interrupt; present only with the optional feature, otherwise tied 0

Behaviour:
- Reset (asynchronous, active-high): all registers, BVALID, RVALID, BRESP, RRESP, RDATA, wr_pulse and irq clear to 0. All READY outputs are 0 during reset and rise on the first clock edge after reset release.
- Index decode: index = addr[ADDR_W-1:ADDR_LSB], where ADDR_LSB = clog2(DW/8). Low address bits are ignored.
- Write FSM states: W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP.
  - W_IDLE: AWREADY=1, WREADY=1.
  - Only AW handshake -> W_HAVE_A; only W handshake -> W_HAVE_D; both in the same cycle -> commit.
  - W_HAVE_A: WREADY=1, AWREADY=0. W_HAVE_D: AWREADY=1, WREADY=0.
  - Address and data are captured in holding registers.
  - Commit occurs on the edge after the second handshake. Bytes with WSTRB set are updated, wr_pulse[index] is high for 1 cycle, BVALID=1, and the FSM enters W_RESP.
  - W_RESP: both READYs are 0. BVALID/BRESP are held until BREADY, then the FSM returns to W_IDLE.
  - Write latency (last handshake to BVALID) is 1 cycle. One write is outstanding at most.
- BRESP:
  - OKAY (00) for a valid RW index.
  - SLVERR (10) when RO_MASK[index]=1; no update, no wr_pulse.
  - DECERR (11) when index >= NUM_REGS; no update, no wr_pulse.
- Read FSM states: R_IDLE, R_RESP.
  - R_IDLE: ARREADY=1. An AR handshake at edge k loads RDATA/RRESP at edge k+1 with RVALID=1.
  - R_RESP: ARREADY=0. RDATA/RRESP are stable until RREADY, then the FSM returns to R_IDLE.
  - Read latency is 1 cycle.
- RDATA source:
  - RW register: register value.
  - RO register: status_in slice, sampled at the load edge.
  - index >= NUM_REGS: RDATA=0, RRESP=DECERR. Otherwise RRESP=OKAY.
- Read and write channels are independent. If a read load and a write commit to the same register fall on the same edge, the read returns the pre-write value.
- WSTRB=0 with a valid RW index: OKAY, no data change, wr_pulse still asserted.
- Reset mid-transaction: holding registers and both FSMs abort to the reset state. No response is ever issued for the aborted transaction.

Optional Feature:
AXI_LITE_REGFILE_IRQ_EN
- Defined:
  - Register NUM_REGS-1 becomes a sticky pending register.
  - Each bit is set by a 1-cycle-high bit of status_in slice NUM_REGS-1 and cleared by a write of 1 to that bit (W1C, strobe-gated). Set wins over a simultaneous clear.
  - irq = |(pending & reg[NUM_REGS-2]), registered, 1 cycle after the cause.
  - RO_MASK[NUM_REGS-1] is ignored.
- Undefined: register NUM_REGS-1 behaves per RO_MASK, and irq is constant 0.

Decomposition:
- Package axi_lite_regfile_pkg:
  - resp codes RESP_OKAY, RESP_SLVERR, RESP_DECERR;
  - wr_state_t and rd_state_t enums;
  - function clog2.
- Sub-module axi_lite_regfile_wch: the write-channel FSM with holding registers. It outputs a commit strobe with index, data and strobe; the top level contains the register array and the read path.

Test Plan:
- Write 0x1,0x2,0x3,0x4 to 0x00,0x04,0x08,0x0C, then read back -> each BRESP=OKAY, RDATA equals the value written, wr_pulse[0..3] each pulse once.
- AWVALID 3 cycles before WVALID, then the reverse order -> exactly one commit, BVALID exactly 1 cycle after the later handshake.
- Reg0=0xFFFFFFFF, then write 0x12345678 with WSTRB=0101 -> reads 0xFF34FF78.
- RO_MASK=0x2, status_in slice 1=0xCAFE: write 0x5 to 0x04 -> SLVERR, read 0x04 -> 0x0000CAFE. Read 0x40 with NUM_REGS=16 -> DECERR, RDATA=0.
- BREADY and RREADY held low for 5 cycles -> BVALID/BRESP and RVALID/RDATA stable throughout, no new AW/AR accepted.
- Assert reset while in W_HAVE_A -> BVALID stays 0, registers read 0 after release. With IRQ_EN: enable reg=0x1, pulse status bit0 -> irq=1; write 0x1 to the pending register -> irq=0.
